// File: rtl/axis_len_framer_if.sv
// AXI4-Stream bundle shared by the framer's payload input and framed output.
// The master modport drives data/valid; the slave modport drives ready.
interface axis_len_framer_if #(
    parameter int unsigned DATA_BITS = 512
) ();
    localparam int unsigned KEEP_BITS = DATA_BITS / 8;

    logic [DATA_BITS-1:0] tdata;
    logic [KEEP_BITS-1:0] tkeep;
    logic                 tlast;
    logic                 tvalid;
    logic                 tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_len_framer.sv
// Frames a dense payload byte stream into AXI4-Stream packets, one per length descriptor,
// generating tkeep/tlast on the final beat. Output stage is a single full-throughput register.
module axis_len_framer #(
    parameter int unsigned AXI4S_DATA_BITS = 512,
    parameter int unsigned LEN_BITS        = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                s_meta_valid,
    output logic                s_meta_ready,
    input  logic [LEN_BITS-1:0] s_meta_data,
    axis_len_framer_if.slave    s_axis,
    axis_len_framer_if.master   m_axis,
    output logic [31:0]         pkt_cnt
);
    localparam int unsigned KEEP_BITS = AXI4S_DATA_BITS / 8;
    localparam int unsigned KB        = $clog2(KEEP_BITS);
    // One extra bit so a length of 2^LEN_BITS-1 rounds up without overflow.
    localparam int unsigned BL_BITS   = LEN_BITS - KB + 1;

    localparam logic [KEEP_BITS-1:0] KEEP_ALL = {KEEP_BITS{1'b1}};

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e state_q, state_d;

    logic [BL_BITS-1:0]         beats_left_q, beats_left_d;
    logic [KEEP_BITS-1:0]       last_keep_q, last_keep_d;
    logic [AXI4S_DATA_BITS-1:0] m_tdata_q, m_tdata_d;
    logic [KEEP_BITS-1:0]       m_tkeep_q, m_tkeep_d;
    logic                       m_tlast_q, m_tlast_d;
    logic                       m_tvalid_q, m_tvalid_d;
    logic [31:0]                pkt_cnt_q, pkt_cnt_d;

    logic                 meta_ready;
    logic                 in_ready;
    logic                 meta_fire;
    logic                 meta_nonzero;
    logic                 in_fire;
    logic                 last_beat;
    logic [KB-1:0]        len_rem;
    logic [BL_BITS-1:0]   meta_beats;
    logic [KEEP_BITS-1:0] meta_keep;

    // Input framing hints are intentionally ignored: the descriptor alone defines packets.
    logic unused_s_axis;
    assign unused_s_axis = ^{s_axis.tkeep, s_axis.tlast};

    assign meta_fire    = s_meta_valid & meta_ready;
    assign meta_nonzero = (s_meta_data != '0);
    assign in_fire      = s_axis.tvalid & in_ready;
    assign last_beat    = (beats_left_q == BL_BITS'(1));

    assign len_rem    = s_meta_data[KB-1:0];
    assign meta_beats = BL_BITS'(s_meta_data[LEN_BITS-1:KB]) + BL_BITS'(len_rem != '0);
    assign meta_keep  = (len_rem == '0) ? KEEP_ALL : ~(KEEP_ALL << len_rem);

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (meta_fire && meta_nonzero) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (in_fire && last_beat) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs; input ready follows downstream ready combinationally.
    always_comb begin
        meta_ready = 1'b0;
        in_ready   = 1'b0;
        unique case (state_q)
            StIdle:   meta_ready = 1'b1;
            StStream: in_ready   = !m_tvalid_q || m_axis.tready;
            default: begin
                meta_ready = 1'b0;
                in_ready   = 1'b0;
            end
        endcase
    end

    // Beat counter and tail keep captured from the descriptor.
    always_comb begin
        beats_left_d = beats_left_q;
        last_keep_d  = last_keep_q;
        if (meta_fire && meta_nonzero) begin
            beats_left_d = meta_beats;
            last_keep_d  = meta_keep;
        end else if (in_fire) begin
            beats_left_d = beats_left_q - BL_BITS'(1);
        end
    end

    // Output register: load wins over drain so a simultaneous load/drain stays valid.
    always_comb begin
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        m_tvalid_d = m_tvalid_q;
        if (in_fire) begin
            m_tdata_d  = s_axis.tdata;
            m_tkeep_d  = last_beat ? last_keep_q : KEEP_ALL;
            m_tlast_d  = last_beat;
            m_tvalid_d = 1'b1;
        end else if (m_axis.tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (m_tvalid_q && m_axis.tready && m_tlast_q) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beats_left_q <= '0;
            last_keep_q  <= '0;
            m_tdata_q    <= '0;
            m_tkeep_q    <= '0;
            m_tlast_q    <= 1'b0;
            m_tvalid_q   <= 1'b0;
            pkt_cnt_q    <= '0;
        end else begin
            beats_left_q <= beats_left_d;
            last_keep_q  <= last_keep_d;
            m_tdata_q    <= m_tdata_d;
            m_tkeep_q    <= m_tkeep_d;
            m_tlast_q    <= m_tlast_d;
            m_tvalid_q   <= m_tvalid_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    assign s_meta_ready  = meta_ready;
    assign s_axis.tready = in_ready;
    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tkeep  = m_tkeep_q;
    assign m_axis.tlast  = m_tlast_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign pkt_cnt       = pkt_cnt_q;
endmodule
